imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive fetch grants while the load port waits.
REQ-002 Parameter: ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; the block SHALL treat reset as synchronous and active-high.
REQ-005 f_req  input  1  fetch-port read request.
REQ-006 f_addr  input  ADDR_W  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  32  fetch read data, little-endian word.
REQ-010 l_req  input  1  load/debug-port request.
REQ-011 l_we  input  1  load-port write enable: 1 = write, 0 = read.
REQ-012 l_addr  input  ADDR_W  load-port byte address.
REQ-013 l_wdata  input  32  load-port write data.
REQ-014 l_gnt  output  1  load request accepted this cycle.
REQ-015 l_rvalid  output  1  load read data valid.
REQ-016 l_rdata  output  32  load read data.
REQ-017 l_err  output  1  one-cycle pulse: misaligned load request rejected.
REQ-018 mem_cs_n  output  1  memory chip select, active-low.
REQ-019 mem_we  output  1  memory write strobe.
REQ-020 mem_addr  output  ADDR_W  memory byte address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rdata  input  32  memory read data, valid the cycle after mem_cs_n low with mem_we=0.

Function
REQ-023 f_gnt, l_gnt, mem_cs_n, mem_we, mem_addr and mem_wdata SHALL be combinational from requests and registered state; at most one grant per cycle.
REQ-024 Arbitration: fetch wins by default; load wins when the starvation counter equals STARVE_LIMIT or f_req=0.
REQ-025 Starvation counter: increments on each f_gnt while l_req=1; clears on l_gnt or when l_req=0; saturates at STARVE_LIMIT.
REQ-026 On any grant, mem_cs_n=0 and mem_addr/mem_we/mem_wdata SHALL carry the granted port's values; otherwise mem_cs_n=1 and mem_we=0.
REQ-027 Read latency: exactly 1 cycle from grant to rvalid; a registered owner tag (NONE/FETCH/LOAD) selects the port.
REQ-028 rdata SHALL equal mem_rdata in the rvalid cycle; the non-owner rvalid SHALL be 0.
REQ-029 Load writes SHALL produce no rvalid; the write completes in the grant cycle.
REQ-030 Back-to-back grants allowed every cycle; a grant in cycle N+1 SHALL NOT disturb the response for cycle N.
REQ-031 Load request with l_addr[1:0]!=0 SHALL NOT be granted or reach memory; l_err pulses 1 in the next cycle; the counter clears as if granted.
REQ-032 Fetch misalignment is not checked; f_addr SHALL be passed through unmodified.
REQ-033 Requesters SHALL hold req and payload stable until gnt; the arbiter SHALL NOT buffer requests.

Reset
REQ-034 While rst=1: f_gnt=l_gnt=0, mem_cs_n=1, mem_we=0, and no memory access issued.
REQ-035 After the reset edge: f_rvalid=l_rvalid=l_err=0, owner tag NONE, starvation counter 0.
REQ-036 A reset asserted the cycle after a grant SHALL suppress the pending rvalid.

Verification
REQ-037 f_req=1 only, f_addr=0x10, mem_rdata=0x00500093 -> f_gnt=1 cycle 0; f_rvalid=1 and f_rdata=0x00500093 cycle 1.
REQ-038 f_req and l_req held high (read, 0x100), STARVE_LIMIT=4 -> four f_gnt, then one l_gnt, then the counter restarts.
REQ-039 l_req=1, l_we=1, l_addr=0x20, l_wdata=0xDEADBEEF -> mem_cs_n=0, mem_we=1, mem_wdata=0xDEADBEEF; no l_rvalid.
REQ-040 l_req=1, l_addr=0x22 -> l_gnt=0, mem_cs_n=1, l_err=1 the next cycle.
REQ-041 f_gnt at 0x0 then rst=1 next cycle -> f_rvalid=0; all outputs at reset values.
REQ-042 Alternating f/l reads every cycle -> each rvalid on the correct port exactly 1 cycle after its grant; no loss.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-ported instruction memory.
// The fetch port normally owns the memory; the load/debug port gets the
// memory when fetch is idle or when it has waited through STARVE_LIMIT
// consecutive fetch grants. Grants and memory strobes are combinational;
// read data returns one cycle after the grant on the port that won.
module imem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,

    output logic              mem_cs_n,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Which port the memory read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOAD
    } owner_t;

    owner_t           owner;
    owner_t           owner_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             err_q;
    logic             err_next;
    logic             load_turn;
    logic             load_aligned;
    logic             load_reject;

    // Arbitration, memory strobes and next-state for owner, counter and error.
    always_comb begin
        load_aligned = (l_addr[1:0] == 2'b00);
        load_turn    = 1'b0;
        load_reject  = 1'b0;
        l_gnt        = 1'b0;
        f_gnt        = 1'b0;
        mem_cs_n     = 1'b1;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        owner_next   = OWN_NONE;
        starve_next  = starve_cnt;
        err_next     = 1'b0;

        if (!rst) begin
            // A misaligned load that wins its turn is dropped instead of
            // granted, which leaves the slot free for a waiting fetch.
            load_turn   = l_req && ((starve_cnt == CNT_MAX) || !f_req);
            l_gnt       = load_turn && load_aligned;
            load_reject = load_turn && !load_aligned;
            f_gnt       = f_req && !l_gnt;
            err_next    = load_reject;

            if (l_gnt) begin
                mem_cs_n  = 1'b0;
                mem_we    = l_we;
                mem_addr  = l_addr;
                mem_wdata = l_wdata;
            end else if (f_gnt) begin
                mem_cs_n  = 1'b0;
                mem_addr  = f_addr;
            end

            if (f_gnt) begin
                owner_next = OWN_FETCH;
            end else if (l_gnt && !l_we) begin
                owner_next = OWN_LOAD;
            end

            // The load port's wait ends when it is served or rejected, or
            // when it stops asking; otherwise each fetch grant lengthens it.
            if (!l_req || load_turn) begin
                starve_next = '0;
            end else if (f_gnt && (starve_cnt != CNT_MAX)) begin
                starve_next = starve_cnt + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            owner      <= owner_next;
            starve_cnt <= starve_next;
            err_q      <= err_next;
        end
    end

    // Responses are masked while reset is held so a read granted just
    // before reset never reports data.
    assign f_rvalid = !rst && (owner == OWN_FETCH);
    assign l_rvalid = !rst && (owner == OWN_LOAD);
    assign f_rdata  = f_rvalid ? mem_rdata : 32'h0;
    assign l_rdata  = l_rvalid ? mem_rdata : 32'h0;
    assign l_err    = !rst && err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, a held
// starvation sequence, and randomized traffic against a reference model.
module tb_imem_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        rst;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        l_req;
   logic        l_we;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic        l_err;
   logic        mem_cs_n;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic        fReq;
      logic [31:0] fAddr;
      logic        lReq;
      logic        lWe;
      logic [31:0] lAddr;
      logic [31:0] lWdata;
      logic [31:0] memRdata;
      logic        eFGnt;
      logic        eLGnt;
      logic        eCsN;
      logic        eWe;
      logic [31:0] eAddr;
      logic [31:0] eWdata;
      logic        eFRvalid;
      logic [31:0] eFRdata;
      logic        eLRvalid;
      logic [31:0] eLRdata;
      logic        eLErr;
   } vecT;

   vecT vecs[$];

   // Reference model state: how many fetch grants the load port has sat
   // through, and what the previous cycle promised to deliver.
   int   streak  = 0;
   logic pendF   = 1'b0;
   logic pendL   = 1'b0;
   logic pendErr = 1'b0;

   imem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_gnt    (f_gnt),
      .f_rvalid (f_rvalid),
      .f_rdata  (f_rdata),
      .l_req    (l_req),
      .l_we     (l_we),
      .l_addr   (l_addr),
      .l_wdata  (l_wdata),
      .l_gnt    (l_gnt),
      .l_rvalid (l_rvalid),
      .l_rdata  (l_rdata),
      .l_err    (l_err),
      .mem_cs_n (mem_cs_n),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual=running, required=finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      rst       = v.rst;
      f_req     = v.fReq;
      f_addr    = v.fAddr;
      l_req     = v.lReq;
      l_we      = v.lWe;
      l_addr    = v.lAddr;
      l_wdata   = v.lWdata;
      mem_rdata = v.memRdata;
   endtask

   // Drive one cycle's inputs just after the edge, compare mid-cycle,
   // then advance to just past the next rising edge.
   task automatic runVec(input string tag, input vecT v);
      applyStimulus(v);
      #4;
      checkOutput({tag, " f_gnt"},    32'(f_gnt),    32'(v.eFGnt));
      checkOutput({tag, " l_gnt"},    32'(l_gnt),    32'(v.eLGnt));
      checkOutput({tag, " mem_cs_n"}, 32'(mem_cs_n), 32'(v.eCsN));
      checkOutput({tag, " mem_we"},   32'(mem_we),   32'(v.eWe));
      checkOutput({tag, " f_rvalid"}, 32'(f_rvalid), 32'(v.eFRvalid));
      checkOutput({tag, " l_rvalid"}, 32'(l_rvalid), 32'(v.eLRvalid));
      checkOutput({tag, " l_err"},    32'(l_err),    32'(v.eLErr));
      if (v.eFGnt || v.eLGnt) begin
         checkOutput({tag, " mem_addr"},  mem_addr,  v.eAddr);
         checkOutput({tag, " mem_wdata"}, mem_wdata, v.eWdata);
      end
      if (v.eFRvalid) checkOutput({tag, " f_rdata"}, f_rdata, v.eFRdata);
      if (v.eLRvalid) checkOutput({tag, " l_rdata"}, l_rdata, v.eLRdata);
      @(posedge clk);
      #1;
   endtask

   // Fill in expectations from the arbitration rules, then advance the model.
   task automatic modelPredict(input vecT vin, output vecT v);
      logic loadTurn, aligned, gl, gf, rej;
      v = vin;
      loadTurn = !v.rst && v.lReq && (streak >= LIMIT || !v.fReq);
      aligned  = (v.lAddr % 4) == 0;
      gl  = loadTurn && aligned;
      rej = loadTurn && !aligned;
      gf  = !v.rst && v.fReq && !gl;
      v.eFGnt    = gf;
      v.eLGnt    = gl;
      v.eCsN     = !(gf || gl);
      v.eWe      = gl && v.lWe;
      v.eAddr    = gl ? v.lAddr : v.fAddr;
      v.eWdata   = gl ? v.lWdata : 32'h0;
      v.eFRvalid = pendF && !v.rst;
      v.eLRvalid = pendL && !v.rst;
      v.eLErr    = pendErr && !v.rst;
      v.eFRdata  = v.memRdata;
      v.eLRdata  = v.memRdata;
      if (v.rst) begin
         streak  = 0;
         pendF   = 1'b0;
         pendL   = 1'b0;
         pendErr = 1'b0;
      end else begin
         if (!v.lReq || loadTurn) streak = 0;
         else if (streak < LIMIT) streak = streak + 1;
         pendF   = gf;
         pendL   = gl && !v.lWe;
         pendErr = rej;
      end
   endtask

   // Main test sequence.
   initial begin
      vecT v;
      vecT w;
      logic [31:0] r;

      applyStimulus('{default: '0});
      rst = 1'b1;
      @(posedge clk);
      #1;

      //                 rst fReq fAddr       lReq lWe lAddr       lWdata        memRdata        eF eL eCsN eWe eAddr     eWdata        eFRv eFRd          eLRv eLRd          eErr
      vecs.push_back('{1'b1,1'b1,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b1,32'h10,      1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b1,1'b0,1'b0,1'b0,32'h10,  32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h00500093,   1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b1,32'h00500093,  1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b1,32'h20,    32'hDEADBEEF, 32'h0,          1'b0,1'b1,1'b0,1'b1,32'h20,  32'hDEADBEEF, 1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h12345678,   1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h22,    32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b1,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b1,1'b1,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'hCAFEF00D,   1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'hCAFEF00D,   1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b1,32'h40,      1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b1,1'b0,1'b0,1'b0,32'h40,  32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h80,    32'h0,        32'h11111111,   1'b0,1'b1,1'b0,1'b0,32'h80,  32'h0,        1'b1,32'h11111111,  1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b1,32'h44,      1'b0,1'b0,32'h0,     32'h0,        32'h22222222,   1'b1,1'b0,1'b0,1'b0,32'h44,  32'h0,        1'b0,32'h0,         1'b1,32'h22222222,  1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h84,    32'h0,        32'h33333333,   1'b0,1'b1,1'b0,1'b0,32'h84,  32'h0,        1'b1,32'h33333333,  1'b0,32'h0,         1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h44444444,   1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b1,32'h44444444,  1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,     32'h0,        32'h0,          1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,        1'b0,32'h0,         1'b0,32'h0,         1'b0});

      $display("[TB] directed vectors: %0d rows", vecs.size());
      foreach (vecs[i]) runVec($sformatf("row%0d", i), vecs[i]);

      // Both ports held: LIMIT fetch grants, one load grant, then again.
      $display("[TB] starvation sequence");
      for (int i = 0; i <= 10; i++) begin
         v = '{default: '0};
         v.fReq     = (i < 10);
         v.fAddr    = 32'h0;
         v.lReq     = (i < 10);
         v.lAddr    = 32'h100;
         v.memRdata = 32'h01010101 * i;
         v.eLGnt    = (i == 4) || (i == 9);
         v.eFGnt    = (i < 10) && !v.eLGnt;
         v.eCsN     = !(v.eFGnt || v.eLGnt);
         v.eAddr    = v.eLGnt ? 32'h100 : 32'h0;
         v.eFRvalid = (i >= 1) && (i != 5) && (i != 10);
         v.eFRdata  = v.memRdata;
         v.eLRvalid = (i == 5) || (i == 10);
         v.eLRdata  = v.memRdata;
         runVec($sformatf("starve%0d", i), v);
      end

      // Randomized traffic, beginning with a reset cycle to align the model.
      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         v = '{default: '0};
         v.rst      = (i == 0) || ($urandom_range(0, 39) == 0);
         v.fReq     = $urandom_range(0, 2) != 0;
         v.fAddr    = $urandom;
         v.lReq     = $urandom_range(0, 1) == 1;
         v.lWe      = $urandom_range(0, 2) == 0;
         r          = $urandom;
         v.lAddr    = (r & ~32'h3) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         v.lWdata   = $urandom;
         v.memRdata = $urandom;
         modelPredict(v, w);
         runVec($sformatf("rand%0d", i), w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
